// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, round-constant table, schedule
// state encoding and the word / round-key types.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Forward AES S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants indexed directly by round number (1..10). Entry 0 and
    // entries 11..15 are unused and padded with zero so any 4-bit index is legal.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes128_inv_key_sched_if.sv
// Key-in / round-key-out channel of the inverse key schedule.
// Handshakes: a beat transfers on a rising clk edge where valid && ready are
// both high; the sender holds data stable and valid high until that edge.
// state_dbg mirrors the schedule FSM state for observation.
interface aes128_inv_key_sched_if;
    import aes_pkg::*;

    rkey_t       key_in;
    logic        key_valid;
    logic        key_ready;
    rkey_t       rk_out;
    logic [3:0]  rk_round;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        busy;
    state_t      state_dbg;

    // Key supplier / round-key consumer side.
    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_out, rk_round, rk_valid, rk_last, busy, state_dbg
    );

    // Schedule side.
    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_out, rk_round, rk_valid, rk_last, busy, state_dbg
    );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w_in,
    output word_t w_out
);
    assign w_out = {sbox(w_in[31:24]), sbox(w_in[23:16]),
                    sbox(w_in[15:8]),  sbox(w_in[7:0])};
endmodule

// File: rtl/aes128_inv_key_sched.sv
// Iterative AES-128 inverse key schedule. Takes the round-LAST_ROUND key and
// streams round keys LAST_ROUND down to 0, one per accepted beat.
// Optional macro AES_INVKS_ZEROIZE_EN: clears the key register when the final
// beat is taken so no key material lingers once the stream is done.
module aes128_inv_key_sched
    import aes_pkg::*;
#(
    parameter int LAST_ROUND = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes128_inv_key_sched_if.slave  bus
);
    if (LAST_ROUND < 1 || LAST_ROUND > 10) begin : g_bad_last_round
        $error("aes128_inv_key_sched: LAST_ROUND must be in 1..10");
    end

    state_t     state_q, state_d;
    rkey_t      key_q, key_d;
    logic [3:0] round_q, round_d;

    word_t w0, w1, w2, w3;
    word_t p0, p1, p2, p3;
    word_t rot_p3, sub_p3;
    rkey_t prev_key;

    // One step backwards through the schedule, using the current round's Rcon.
    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    aes_sub_word u_sub_word (
        .w_in  (rot_p3),
        .w_out (sub_p3)
    );

    assign p0       = w0 ^ sub_p3 ^ {RCON[round_q], 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    // State, key and round registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // Next state: load on key acceptance, step back on each taken beat.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = EMIT;
                    key_d   = bus.key_in;
                    round_d = 4'(LAST_ROUND);
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = IDLE;
`ifdef AES_INVKS_ZEROIZE_EN
                        key_d   = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers; rk_ready never reaches rk_out.
    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = (state_q == EMIT);
    assign bus.busy      = (state_q == EMIT);
    assign bus.rk_last   = (state_q == EMIT) && (round_q == 4'd0);
    assign bus.rk_out    = key_q;
    assign bus.rk_round  = round_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Bench for aes128_inv_key_sched. Expected round keys come from a forward
// AES-128 key expansion built from GF(2^8) arithmetic, replayed in reverse.
module tb_aes128_inv_key_sched;

    localparam int LR = 10;

    logic clk;
    logic rst_n;

    aes128_inv_key_sched_if bus();

    aes128_inv_key_sched #(.LAST_ROUND(LR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   ref_sbox [256];
    logic [7:0]   ref_rcon [11];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] rc = 8'h01;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        ref_rcon[0] = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            ref_rcon[i] = rc;
            rc = xtime(rc);
        end
    endtask

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
                t = t ^ {ref_rcon[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Loads the scoreboard with the descending stream; returns the key to feed.
    task automatic load_exp(input logic [127:0] k0, output logic [127:0] feed);
        expand(k0);
        exp_q.delete();
        for (int r = LR; r >= 0; r--) exp_q.push_back(exp_rk[r]);
        feed = exp_rk[LR];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_key_ready"}, 128'(bus.key_ready), 128'd1);
        check_eq({tag, "_rk_valid"},  128'(bus.rk_valid),  128'd0);
        check_eq({tag, "_rk_out"},    bus.rk_out,          128'd0);
        check_eq({tag, "_rk_round"},  128'(bus.rk_round),  128'd0);
        check_eq({tag, "_rk_last"},   128'(bus.rk_last),   128'd0);
        check_eq({tag, "_busy"},      128'(bus.busy),      128'd0);
    endtask

    // driver tasks
    task automatic send_key(input logic [127:0] key);
        @(negedge clk);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        check_eq("send_key_ready", 128'(bus.key_ready), 128'd1);
    endtask

    // Consumes one stream, checking every sampled beat against the scoreboard.
    task automatic collect(input bit bp, input bit inject_busy, input logic [127:0] other_key,
                           input bit b2b, input logic [127:0] next_key, input int reset_at);
        int r = LR;
        int cycles = 0;
        bit done = 1'b0;
        bit aborted = 1'b0;
        bit injected = 1'b0;
        bit stalled = 1'b0;
        logic [127:0] prev_out = '0;
        logic [3:0]   prev_round = '0;
        while (!done) begin
            @(negedge clk);
            cycles++;
            if (cycles > 400) begin
                check_eq("stream_timeout", 128'(cycles), 128'd400);
                aborted = 1'b1;
                break;
            end
            check_eq("rk_valid",  128'(bus.rk_valid),  128'd1);
            check_eq("rk_round",  128'(bus.rk_round),  128'(r));
            check_eq("rk_last",   128'(bus.rk_last),   128'(r == 0));
            check_eq("busy",      128'(bus.busy),      128'd1);
            check_eq("key_ready_busy", 128'(bus.key_ready), 128'd0);
            if (exp_q.size() > 0) check_eq("rk_out", bus.rk_out, exp_q[0]);
            else                  check_eq("exp_q_empty", 128'(exp_q.size()), 128'd1);
            if (stalled) begin
                check_eq("stall_rk_out",   bus.rk_out,          prev_out);
                check_eq("stall_rk_round", 128'(bus.rk_round),  128'(prev_round));
            end
            got_rk[r] = bus.rk_out;
            if (reset_at == r) begin
                rst_n = 1'b0;
                bus.key_valid = 1'b0;
                bus.rk_ready  = 1'b1;
                #1;
                check_reset_outputs("midrun_reset");
                @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            bus.key_valid = 1'b0;
            if (inject_busy && r == 5 && !injected) begin
                bus.key_in    = other_key;
                bus.key_valid = 1'b1;
                injected      = 1'b1;
            end
            bus.rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b2b && r == 0 && bus.rk_ready) begin
                bus.key_in    = next_key;
                bus.key_valid = 1'b1;
            end
            stalled    = !bus.rk_ready;
            prev_out   = bus.rk_out;
            prev_round = bus.rk_round;
            if (bus.rk_ready) begin
                void'(exp_q.pop_front());
                if (r == 0) done = 1'b1;
                else        r--;
            end
        end
        if (!aborted) begin
            if (!bp) check_eq("stream_cycles", 128'(cycles), 128'(LR + 1));
            @(negedge clk);
            check_eq("end_rk_valid",  128'(bus.rk_valid),  128'd0);
            check_eq("end_key_ready", 128'(bus.key_ready), 128'd1);
            check_eq("end_busy",      128'(bus.busy),      128'd0);
            check_eq("end_rk_last",   128'(bus.rk_last),   128'd0);
`ifdef AES_INVKS_ZEROIZE_EN
            check_eq("end_zeroized",  bus.rk_out,          128'd0);
`endif
        end
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // main sequence and final report
    initial begin
        logic [127:0] feed;
        logic [127:0] k0a, k0b, next_feed;

        rst_n         = 1'b0;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        build_tables();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // FIPS-197 A.1 vector, consumer always ready
        load_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, feed);
        send_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        collect(1'b0, 1'b0, '0, 1'b0, '0, -1);
        check_eq("fips_round9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check_eq("fips_round0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Same key with random backpressure
        load_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, feed);
        send_key(feed);
        collect(1'b1, 1'b0, '0, 1'b0, '0, -1);

        // Key offered while busy must be ignored
        load_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, feed);
        send_key(feed);
        collect(1'b1, 1'b1, rand128(), 1'b0, '0, -1);

        // Back-to-back: next key held valid during the final beat
        k0a = rand128();
        k0b = rand128();
        load_exp(k0b, next_feed);
        load_exp(k0a, feed);
        send_key(feed);
        collect(1'b0, 1'b0, '0, 1'b1, next_feed, -1);
        load_exp(k0b, feed);
        collect(1'b0, 1'b0, '0, 1'b0, '0, -1);

        // Reset in the middle of a stream, then a fresh run
        load_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, feed);
        send_key(feed);
        collect(1'b0, 1'b0, '0, 1'b0, '0, 4);
        check_eq("post_reset_key_ready", 128'(bus.key_ready), 128'd1);
        load_exp(rand128(), feed);
        send_key(feed);
        collect(1'b1, 1'b0, '0, 1'b0, '0, -1);

        // Random keys under random backpressure
        for (int i = 0; i < 4; i++) begin
            load_exp(rand128(), feed);
            send_key(feed);
            collect(1'b1, 1'b0, '0, 1'b0, '0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes128_inv_key_sched.md
Name: aes128_inv_key_sched

Overview:
- Iterative AES-128 inverse key schedule. It is the reverse direction of the round-key expansion sub-blocks.
- Accepts the round-LAST_ROUND key and streams round keys LAST_ROUND down to 0 over a valid/ready interface, one key per accepted beat.
- Feeds the decryption datapath, which consumes round keys in reverse order without storing the full expanded schedule.

Parameters:
- LAST_ROUND, 10, index of the round key supplied on key_in. Legal range 1..10; out-of-range values are a compile-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  128  round-LAST_ROUND key; word0 = key_in[127:96], word3 = key_in[31:0]
- key_valid  input  1  key_in valid
- key_ready  output  1  block can accept a key (high only in IDLE)
- rk_out  output  128  current round key, same word order as key_in
- rk_round  output  4  round index of rk_out
- rk_valid  output  1  rk_out/rk_round valid
- rk_ready  input  1  consumer accepts the current beat
- rk_last  output  1  high with rk_valid when rk_round == 0
- busy  output  1  high whenever the state is EMIT

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: state IDLE, key register 0, round register 0. Outputs: rk_out 0, rk_round 0, rk_valid 0, rk_last 0, busy 0, key_ready 1.
- States:
  - IDLE: key_ready=1.
  - EMIT: rk_valid=1, key_ready=0.
- IDLE -> EMIT on key_valid && key_ready. Key register <= key_in; round <= LAST_ROUND.
  - rk_valid rises on the cycle after acceptance, with rk_out = key_in.
- In EMIT, on rk_valid && rk_ready:
  - rk_round != 0: key register <= prev(key); round <= round-1; rk_valid stays 1.
  - rk_round == 0: go to IDLE; rk_valid = 0 and key_ready = 1 on the next cycle.
- No beat is dropped or skipped under backpressure.
  - rk_ready low: rk_out and rk_round hold stable and rk_valid stays high.
- rk_out and rk_round are driven directly from registers. No combinational path from rk_ready to rk_out.
- prev() function. Input words w0..w3, current round r. Compute in order:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
- RotWord([a,b,c,d]) = [b,c,d,a]. SubWord applies the forward AES S-box to each byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Rcon is a constant table indexed by r, not a shift.
- Throughput: one key per cycle with rk_ready held high. A full run is LAST_ROUND+1 beats; input acceptance to last beat takes LAST_ROUND+1 cycles.
- key_valid while busy is ignored; key_ready=0 then.
- Key acceptance and the final beat never coincide, because key_ready=0 in EMIT. A new key is accepted no earlier than the cycle after the last beat.
- Reset asserted mid-run: immediate return to reset values; a partial stream is abandoned.

Optional Feature:
- Macro AES_INVKS_ZEROIZE_EN.
- Defined: on the IDLE transition after the final handshake, the key register is cleared to 0. rk_out therefore reads 0 whenever rk_valid=0.
- Not defined: the key register keeps the round-0 key after completion. rk_out is don't-care when rk_valid=0.
- Handshake timing is identical in both cases.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry forward S-box constant
  - the Rcon table
  - a state enum (IDLE, EMIT)
  - a 128-bit round-key typedef and a 32-bit word typedef
- One natural sub-module: aes_sub_word. It holds four combinational S-box lookups on a 32-bit word and is reusable by the forward schedule.

Test Plan:
- FIPS-197 A.1: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6 with LAST_ROUND=10, rk_ready tied high.
  - Required: 11 consecutive beats.
  - Beat round 9 = ac7766f319fadc2128d12941575c006e.
  - Final beat round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with rk_last=1.
- Backpressure: same key with rk_ready toggled as a pseudo-random pattern.
  - Required: identical 11-value sequence; rk_out/rk_round stable while rk_valid && !rk_ready.
- Busy input: pulse key_valid with a different key during beat round 5.
  - Required: key_ready=0, the pulse is ignored, and the sequence is unchanged.
- Back-to-back: drive the next key_valid high during the final beat.
  - Required: key accepted exactly one cycle after the last handshake; rk_valid rises the following cycle with round 10.
- Mid-run reset: assert rst_n=0 at beat round 4.
  - Required: all outputs at reset values immediately; after release, key_ready=1 and a fresh key restarts at round 10.
- Zeroize variant, compiled with AES_INVKS_ZEROIZE_EN.
  - Required: after the final beat, rk_out = 0 and rk_valid = 0.
